// File: rtl/afu_math_pkg.sv
// Shared opcodes, FSM encoding and bit layouts for the AFU math command sequencer.
package afu_math_pkg;

   localparam logic [31:0] OP_ADD = 32'd1;
   localparam logic [31:0] OP_SUB = 32'd2;
   localparam logic [31:0] OP_MUL = 32'd3;
   localparam logic [31:0] OP_DIV = 32'd4;
   localparam logic [31:0] OP_MOD = 32'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_RD_REQ, S_RD_RSP, S_ALU_REQ,
      S_ALU_WAIT, S_WR_REQ, S_WR_RSP, S_DONE
   } state_e;

   localparam int CTX_NUM_LSB = 0;
   localparam int CTX_SRC_LSB = 32;
   localparam int CTX_DST_LSB = 64;

   localparam int CMD_OP_LSB  = 0;
   localparam int CMD_A_LSB   = 32;
   localparam int CMD_B_LSB   = 64;

   localparam int RES_VAL_LSB = 0;
   localparam int RES_ERR_BIT = 64;
   localparam int RES_OP_LSB  = 96;
   localparam int RES_MIN_W   = 128;

   function automatic logic op_valid(input logic [31:0] op);
      return (op >= OP_ADD) && (op <= OP_MOD);
   endfunction

endpackage

// File: rtl/afu_math_sched_if.sv
// Cache read/write channels, ALU handshake and control/status of the math sequencer.
interface afu_math_sched_if #(
   parameter int ADDR_LMT    = 20,
   parameter int MDATA       = 14,
   parameter int CACHE_WIDTH = 512
);
   logic                   start;
   logic [511:0]           afu_context;
   logic [ADDR_LMT-1:0]    rd_req_addr;
   logic [MDATA-1:0]       rd_req_mdata;
   logic                   rd_req_en;
   logic                   rd_req_almostfull;
   logic                   rd_rsp_valid;
   logic [MDATA-1:0]       rd_rsp_mdata;
   logic [CACHE_WIDTH-1:0] rd_rsp_data;
   logic [ADDR_LMT-1:0]    wr_req_addr;
   logic [MDATA-1:0]       wr_req_mdata;
   logic [CACHE_WIDTH-1:0] wr_req_data;
   logic                   wr_req_en;
   logic                   wr_req_almostfull;
   logic                   wr_rsp0_valid;
   logic [MDATA-1:0]       wr_rsp0_mdata;
   logic                   wr_rsp1_valid;
   logic [MDATA-1:0]       wr_rsp1_mdata;
   logic                   alu_req_valid;
   logic                   alu_req_ready;
   logic [2:0]             alu_op;
   logic [31:0]            alu_a;
   logic [31:0]            alu_b;
   logic                   alu_rsp_valid;
   logic [63:0]            alu_result;
   logic                   done;
   logic [31:0]            err_count;

   modport master (
      input  start, afu_context, rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
             wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
             alu_req_ready, alu_rsp_valid, alu_result,
      output rd_req_addr, rd_req_mdata, rd_req_en, wr_req_addr, wr_req_mdata, wr_req_data,
             wr_req_en, alu_req_valid, alu_op, alu_a, alu_b, done, err_count
   );

   modport slave (
      output start, afu_context, rd_req_almostfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
             wr_req_almostfull, wr_rsp0_valid, wr_rsp0_mdata, wr_rsp1_valid, wr_rsp1_mdata,
             alu_req_ready, alu_rsp_valid, alu_result,
      input  rd_req_addr, rd_req_mdata, rd_req_en, wr_req_addr, wr_req_mdata, wr_req_data,
             wr_req_en, alu_req_valid, alu_op, alu_a, alu_b, done, err_count
   );
endinterface

// File: rtl/afu_math_line_fmt.sv
// Combinational command-line decode/validate and result-line pack.
// Latency: 0 cycles; no backpressure (pure function of its inputs).
module afu_math_line_fmt
   import afu_math_pkg::*;
#(
   parameter int CACHE_WIDTH = 512
) (
   input  logic [CACHE_WIDTH-1:0] cmd_line_i,
   output logic [31:0]            opcode_o,
   output logic [31:0]            a_o,
   output logic [31:0]            b_o,
   output logic [2:0]             alu_op_o,
   output logic                   err_o,
   input  logic [63:0]            result_i,
   input  logic                   err_i,
   input  logic [31:0]            res_opcode_i,
   output logic [CACHE_WIDTH-1:0] res_line_o
);
   // Pack into at least 128 bits so the opcode echo never indexes past a narrow line.
   localparam int PW = (CACHE_WIDTH > RES_MIN_W) ? CACHE_WIDTH : RES_MIN_W;

   logic [PW-1:0] res_wide;
   logic          div_op;
   logic          unused_cmd;

   assign unused_cmd = ^cmd_line_i;

   always_comb begin
      opcode_o = cmd_line_i[CMD_OP_LSB +: 32];
      a_o      = cmd_line_i[CMD_A_LSB +: 32];
      b_o      = cmd_line_i[CMD_B_LSB +: 32];
      alu_op_o = opcode_o[2:0];
      div_op   = (opcode_o == OP_DIV) || (opcode_o == OP_MOD);
      err_o    = !op_valid(opcode_o) || (div_op && (b_o == 32'd0));
   end

   always_comb begin
      res_wide                       = '0;
      res_wide[RES_VAL_LSB +: 64]    = result_i;
      res_wide[RES_ERR_BIT]          = err_i;
      res_wide[RES_OP_LSB +: 32]     = res_opcode_i;
   end

   assign res_line_o = res_wide[CACHE_WIDTH-1:0];

endmodule

// File: rtl/afu_math_sched.sv
// Batched command sequencer: read line, run ALU op, write result line, one line at a time.
// Latency: >=5 cycles per good line plus memory/ALU latency; stalls on almostfull and ALU ready.
module afu_math_sched
   import afu_math_pkg::*;
#(
   parameter int ADDR_LMT    = 20,
   parameter int MDATA       = 14,
   parameter int CACHE_WIDTH = 512
) (
   input  logic             clk,
   input  logic             reset_n,
   afu_math_sched_if.master bus
);
   state_e                 state_q, state_d;
   logic [31:0]            num_q, num_d, src_q, src_d, dst_q, dst_d, idx_q, idx_d;
   logic [31:0]            opcode_q, opcode_d, err_count_q, err_count_d;
   logic                   err_q, err_d, done_q, done_d;
   logic [63:0]            result_q, result_d;
   logic                   rd_en_q, rd_en_d, wr_en_q, wr_en_d, alu_vld_q, alu_vld_d;
   logic [ADDR_LMT-1:0]    rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
   logic [MDATA-1:0]       rd_tag_q, rd_tag_d, wr_tag_q, wr_tag_d, tag;
   logic [CACHE_WIDTH-1:0] wr_data_q, wr_data_d, res_line;
   logic [2:0]             alu_op_q, alu_op_d, dec_alu_op;
   logic [31:0]            alu_a_q, alu_a_d, alu_b_q, alu_b_d, dec_op, dec_a, dec_b;
   logic                   dec_err, rd_hit, wr_hit, alu_hs, unused_ctx;

   afu_math_line_fmt #(.CACHE_WIDTH(CACHE_WIDTH)) u_fmt (
      .cmd_line_i   (bus.rd_rsp_data),
      .opcode_o     (dec_op),
      .a_o          (dec_a),
      .b_o          (dec_b),
      .alu_op_o     (dec_alu_op),
      .err_o        (dec_err),
      .result_i     (result_q),
      .err_i        (err_q),
      .res_opcode_i (opcode_q),
      .res_line_o   (res_line)
   );

   assign tag        = MDATA'(idx_q);
   assign rd_hit     = bus.rd_rsp_valid && (bus.rd_rsp_mdata == tag);
   assign wr_hit     = (bus.wr_rsp0_valid && (bus.wr_rsp0_mdata == tag)) ||
                       (bus.wr_rsp1_valid && (bus.wr_rsp1_mdata == tag));
   assign alu_hs     = alu_vld_q && bus.alu_req_ready;
   assign unused_ctx = ^bus.afu_context;

   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:     if (bus.start) state_d = S_CHECK;
         S_CHECK:    state_d = (idx_q == num_q) ? S_DONE : S_RD_REQ;
         S_RD_REQ:   if (!bus.rd_req_almostfull) state_d = S_RD_RSP;
         S_RD_RSP:   if (rd_hit) state_d = dec_err ? S_WR_REQ : S_ALU_REQ;
         // A zero-latency ALU may answer in the accept cycle itself.
         S_ALU_REQ:  if (alu_hs) state_d = bus.alu_rsp_valid ? S_WR_REQ : S_ALU_WAIT;
         S_ALU_WAIT: if (bus.alu_rsp_valid) state_d = S_WR_REQ;
         S_WR_REQ:   if (!bus.wr_req_almostfull) state_d = S_WR_RSP;
         S_WR_RSP:   if (wr_hit) state_d = S_CHECK;
         S_DONE:     state_d = S_DONE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      num_d = num_q;   src_d = src_q;   dst_d = dst_q;   idx_d = idx_q;
      opcode_d = opcode_q;   err_d = err_q;   result_d = result_q;
      err_count_d = err_count_q;   done_d = done_q;
      rd_en_d = 1'b0;   rd_addr_d = rd_addr_q;   rd_tag_d = rd_tag_q;
      wr_en_d = 1'b0;   wr_addr_d = wr_addr_q;   wr_tag_d = wr_tag_q;   wr_data_d = wr_data_q;
      alu_vld_d = alu_vld_q;   alu_op_d = alu_op_q;   alu_a_d = alu_a_q;   alu_b_d = alu_b_q;
      unique case (state_q)
         S_IDLE: if (bus.start) begin
            num_d = bus.afu_context[CTX_NUM_LSB +: 32];
            src_d = bus.afu_context[CTX_SRC_LSB +: 32];
            dst_d = bus.afu_context[CTX_DST_LSB +: 32];
            idx_d = 32'd0;
         end
         S_CHECK: if (idx_q == num_q) done_d = 1'b1;
         S_RD_REQ: if (!bus.rd_req_almostfull) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_LMT'(src_q + idx_q);
            rd_tag_d  = tag;
         end
         S_RD_RSP: if (rd_hit) begin
            opcode_d  = dec_op;
            alu_op_d  = dec_alu_op;
            alu_a_d   = dec_a;
            alu_b_d   = dec_b;
            err_d     = dec_err;
            result_d  = 64'd0;
            alu_vld_d = !dec_err;
         end
         S_ALU_REQ: if (alu_hs) begin
            alu_vld_d = 1'b0;
            if (bus.alu_rsp_valid) result_d = bus.alu_result;
         end
         S_ALU_WAIT: if (bus.alu_rsp_valid) result_d = bus.alu_result;
         S_WR_REQ: if (!bus.wr_req_almostfull) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_LMT'(dst_q + idx_q);
            wr_tag_d  = tag;
            wr_data_d = res_line;
         end
         S_WR_RSP: if (wr_hit) begin
            if (err_q && (err_count_q != '1)) err_count_d = err_count_q + 32'd1;
            idx_d = idx_q + 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         num_q <= '0;   src_q <= '0;   dst_q <= '0;   idx_q <= '0;
         opcode_q <= '0;   err_q <= 1'b0;   result_q <= '0;
         err_count_q <= '0;   done_q <= 1'b0;
         rd_en_q <= 1'b0;   rd_addr_q <= '0;   rd_tag_q <= '0;
         wr_en_q <= 1'b0;   wr_addr_q <= '0;   wr_tag_q <= '0;   wr_data_q <= '0;
         alu_vld_q <= 1'b0;   alu_op_q <= '0;   alu_a_q <= '0;   alu_b_q <= '0;
      end else begin
         num_q <= num_d;   src_q <= src_d;   dst_q <= dst_d;   idx_q <= idx_d;
         opcode_q <= opcode_d;   err_q <= err_d;   result_q <= result_d;
         err_count_q <= err_count_d;   done_q <= done_d;
         rd_en_q <= rd_en_d;   rd_addr_q <= rd_addr_d;   rd_tag_q <= rd_tag_d;
         wr_en_q <= wr_en_d;   wr_addr_q <= wr_addr_d;   wr_tag_q <= wr_tag_d;   wr_data_q <= wr_data_d;
         alu_vld_q <= alu_vld_d;   alu_op_q <= alu_op_d;   alu_a_q <= alu_a_d;   alu_b_q <= alu_b_d;
      end
   end

   assign bus.rd_req_en     = rd_en_q;
   assign bus.rd_req_addr   = rd_addr_q;
   assign bus.rd_req_mdata  = rd_tag_q;
   assign bus.wr_req_en     = wr_en_q;
   assign bus.wr_req_addr   = wr_addr_q;
   assign bus.wr_req_mdata  = wr_tag_q;
   assign bus.wr_req_data   = wr_data_q;
   assign bus.alu_req_valid = alu_vld_q;
   assign bus.alu_op        = alu_op_q;
   assign bus.alu_a         = alu_a_q;
   assign bus.alu_b         = alu_b_q;
   assign bus.done          = done_q;
   assign bus.err_count     = err_count_q;

endmodule

// File: doc/afu_math_sched.md
Name: afu_math_sched

Overview:
- Command sequencer for the AFU math datapath. Processes a batch of NUM command cache lines per start.
- For each line: reads it from the source region and decodes opcode and operands. Dispatches them to a shared external ALU over a valid/ready handshake, collects the result, and writes a result line to the destination region.
- Sits between the cache read/write request channels and the ALU. Replaces single-shot sequencing with batched, backpressure-aware scheduling.

Parameters:
- ADDR_LMT, 20, cache-line address width
- MDATA, 14, request/response tag width
- CACHE_WIDTH, 512, cache line width (must be >= 96)

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  level; sampled in IDLE only
- afu_context  in  512  [31:0] num_lines, [63:32] src_base, [95:64] dst_base (line addresses)
- rd_req_addr  out  ADDR_LMT  read line address
- rd_req_mdata  out  MDATA  read tag
- rd_req_en  out  1  read request strobe, one cycle
- rd_req_almostfull  in  1  read channel backpressure
- rd_rsp_valid  in  1  read response valid
- rd_rsp_mdata  in  MDATA  read response tag
- rd_rsp_data  in  CACHE_WIDTH  command line: [31:0] opcode, [63:32] a, [95:64] b
- wr_req_addr  out  ADDR_LMT  write line address
- wr_req_mdata  out  MDATA  write tag
- wr_req_data  out  CACHE_WIDTH  result line
- wr_req_en  out  1  write request strobe, one cycle
- wr_req_almostfull  in  1  write channel backpressure
- wr_rsp0_valid  in  1  write response, port 0
- wr_rsp0_mdata  in  MDATA  write response tag, port 0
- wr_rsp1_valid  in  1  write response, port 1
- wr_rsp1_mdata  in  MDATA  write response tag, port 1
- alu_req_valid  out  1  ALU request valid
- alu_req_ready  in  1  ALU accepts the request
- alu_op  out  3  1=add 2=sub 3=mul 4=div 5=mod
- alu_a  out  32  operand a
- alu_b  out  32  operand b
- alu_rsp_valid  in  1  ALU result valid, one-cycle pulse
- alu_result  in  64  ALU result (mul uses all 64 bits; others zero-extended)
- done  out  1  batch complete, sticky
- err_count  out  32  count of lines flagged with an error

Behaviour:
- Reset (sync, reset_n=0): FSM to IDLE. All outputs 0. Index and err_count cleared. Reset mid-batch aborts immediately; an outstanding response arriving later is ignored (IDLE ignores all responses).
- Registered outputs. All outputs are driven from flops. Data buses hold their value between strobes.
- IDLE: on start=1, latch num_lines, src_base, dst_base; idx=0; go to CHECK.
- CHECK: if idx==num_lines, go to DONE (num_lines=0 finishes with no traffic); else go to RD_REQ.
- RD_REQ: when rd_req_almostfull=0, pulse rd_req_en for 1 cycle with addr=(src_base+idx) truncated to ADDR_LMT and mdata=idx[MDATA-1:0]; go to RD_RSP.
- RD_RSP: wait for rd_rsp_valid with rd_rsp_mdata==current tag; latch opcode, a, b. A valid response with a non-matching tag is dropped.
- Decode:
  - Opcode 1-5 with no error: go to ALU_REQ.
  - Opcode outside 1..5: err=1, result=0; skip the ALU and go to WR_REQ.
  - Opcode 4 or 5 with b==0: err=1, result=0; skip the ALU.
- ALU_REQ: hold alu_req_valid=1 with stable op/a/b until alu_req_ready=1 in the same cycle; then deassert and go to ALU_WAIT.
- ALU_WAIT: on alu_rsp_valid, latch alu_result; go to WR_REQ.
- WR_REQ: when wr_req_almostfull=0, pulse wr_req_en with addr=(dst_base+idx) truncated, mdata=idx tag. wr_req_data layout:
  - [63:0] result
  - [64] err
  - [95:65] 0
  - [127:96] echo of the opcode
  - remainder 0
  - Go to WR_RSP.
- WR_RSP: accept a matching tag on rsp0 or rsp1 (both at once counts once). err_count += err (saturates at 0xFFFFFFFF). idx += 1; go to CHECK.
- DONE: done=1, held until reset; start ignored.
- At most one read or write outstanding at any time.
- Address wrap: base+idx overflowing ADDR_LMT wraps modulo 2^ADDR_LMT, no flag.
- Latency per good line: at least 5 cycles plus memory and ALU latency.

Decomposition:
- Package afu_math_pkg:
  - opcode localparams OP_ADD..OP_MOD
  - FSM state encoding (IDLE, CHECK, RD_REQ, RD_RSP, ALU_REQ, ALU_WAIT, WR_REQ, WR_RSP, DONE)
  - context field offsets
  - result-line bit offsets
- Sub-module afu_math_line_fmt (combinational): command decode/validate plus result-line pack. Keeps the FSM file free of bit slicing.

Test Plan:
- num_lines=3, src=0x100, dst=0x200, ops add(7,5)/mul(0x10000,0x10000)/sub(3,5), zero-latency ALU:
  - reads at 0x100..0x102, writes at 0x200..0x202
  - results 12 / 0x1_0000_0000 / 0xFFFFFFFE (zero-extended)
  - done=1, err_count=0
- num_lines=0, start=1 -> done=1 within 3 cycles; no rd_req_en or wr_req_en ever.
- Line op=4, b=0, plus line op=9 -> no alu_req_valid for either; result lines have [64]=1 and [63:0]=0; err_count=2.
- rd_req_almostfull and wr_req_almostfull held high 10 cycles, alu_req_ready low 5 cycles:
  - no strobes while almostfull is high
  - alu_op/a/b stable while valid && !ready
  - final results unchanged
- Stray rd_rsp_valid with wrong mdata before the real one -> ignored; correct line processed once.
- reset_n=0 during ALU_WAIT, then late alu_rsp_valid and wr_rsp0_valid -> all outputs 0, FSM stays IDLE; new start runs a clean batch with err_count from 0.
